// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one request per cycle from an internal pc
// into a single-entry output register. Handles redirects, halt and memory timeouts.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] current_procount,
  output logic        misalign_err,
  output logic        bus_err,
  output logic [31:0] fetch_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;
  localparam logic [1:0] ERROR = 2'd3;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [31:0] pc;
  logic [7:0]  tcnt;
  logic        accept, transfer, stall_tick, expire;

  // A redirect suppresses the request so a stale fetch never goes out.
  assign imem_req   = (state == RUN) && (!inst_valid || inst_ready) && !redirect_valid;
  assign imem_addr  = pc;
  assign accept     = imem_req && imem_ack;
  assign transfer   = inst_valid && inst_ready;
  assign stall_tick = imem_req && !imem_ack;
  // The unacknowledged cycle that brings the counter to TIMEOUT ends the run.
  assign expire     = stall_tick && (tcnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      pc               <= RESET_PC;
      tcnt             <= 8'd0;
      inst_valid       <= 1'b0;
      instruction      <= 32'd0;
      current_procount <= RESET_PC;
      misalign_err     <= 1'b0;
      bus_err          <= 1'b0;
      fetch_count      <= 32'd0;
    end else begin
      misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      tcnt         <= stall_tick ? tcnt + 8'd1 : 8'd0;
      if (transfer)
        fetch_count <= fetch_count + 32'd1;

      if (redirect_valid) begin
        pc         <= {redirect_pc[31:2], 2'b00};
        inst_valid <= 1'b0;
      end else if (accept) begin
        instruction      <= imem_rdata;
        current_procount <= pc;
        inst_valid       <= 1'b1;
        pc               <= pc + 32'd4;
      end else if (transfer) begin
        inst_valid <= 1'b0;
      end

      case (state)
        IDLE:  state <= RUN;
        RUN: begin
          if (expire) begin
            state   <= ERROR;
            bus_err <= 1'b1;
          end else if (halt) begin
            state <= HALT;
          end
        end
        HALT:  if (!halt) state <= RUN;
        ERROR: if (redirect_valid) state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; memory returns addr ^ DPAT so data is predictable.
module tb_fetch_sequencer;
  localparam logic [31:0] DPAT = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] current_procount;
  logic        misalign_err;
  logic        bus_err;
  logic [31:0] fetch_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  assign imem_rdata = imem_addr ^ DPAT;

  fetch_sequencer #(.RESET_PC(32'h0), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .instruction(instruction), .current_procount(current_procount),
    .misalign_err(misalign_err), .bus_err(bus_err), .fetch_count(fetch_count)
  );

  // Leaves the bench at the negedge of the single IDLE cycle after release.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
    imem_ack = 1'b1; inst_ready = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got %h exp 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got %h exp 0", inst_valid); end
    checks++; if (instruction !== 32'h0) begin failures++; $display("FAIL rst_instr got %h exp 0", instruction); end
    checks++; if (current_procount !== 32'h0) begin failures++; $display("FAIL rst_pc got %h exp 0", current_procount); end
    checks++; if ({misalign_err, bus_err} !== 2'b00) begin failures++; $display("FAIL rst_errs got %b exp 00", {misalign_err, bus_err}); end
    checks++; if (fetch_count !== 32'h0) begin failures++; $display("FAIL rst_count got %h exp 0", fetch_count); end
  endtask

  task automatic test_stream();
    imem_ack = 1'b1; inst_ready = 1'b1;
    do_reset(); #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL idle_req got %h exp 0", imem_req); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4*k)) begin
        failures++; $display("FAIL stream_addr k=%0d got req=%h addr=%h exp 1/%h", k, imem_req, imem_addr, 32'(4*k)); end
      if (k >= 1) begin
        checks++; if (current_procount !== 32'(4*(k-1)) || instruction !== (32'(4*(k-1)) ^ DPAT)) begin
          failures++; $display("FAIL stream_out k=%0d got pc=%h ins=%h", k, current_procount, instruction); end
      end
    end
    @(negedge clk); @(negedge clk); #1;
    checks++; if (fetch_count !== 32'd10) begin failures++; $display("FAIL stream_count got %0d exp 10", fetch_count); end
  endtask

  task automatic test_stall();
    imem_ack = 1'b1; inst_ready = 1'b1;
    do_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      inst_ready = 1'b0; #1;
      checks++; if (inst_valid !== 1'b1 || current_procount !== 32'h8 || instruction !== (32'h8 ^ DPAT)) begin
        failures++; $display("FAIL stall_hold i=%0d got v=%h pc=%h ins=%h exp 1/8", i, inst_valid, current_procount, instruction); end
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req i=%0d got %h exp 0", i, imem_req); end
    end
    @(negedge clk);
    inst_ready = 1'b1; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
      failures++; $display("FAIL stall_resume got req=%h addr=%h exp 1/c", imem_req, imem_addr); end
    @(negedge clk); #1;
    checks++; if (current_procount !== 32'hC || fetch_count !== 32'd3) begin
      failures++; $display("FAIL stall_next got pc=%h cnt=%0d exp c/3", current_procount, fetch_count); end
  endtask

  task automatic test_redirect();
    imem_ack = 1'b1; inst_ready = 1'b1;
    do_reset();
    repeat (9) @(negedge clk); #1;
    checks++; if (imem_addr !== 32'h20) begin failures++; $display("FAIL redir_pre got %h exp 20", imem_addr); end
    redirect_valid = 1'b1; redirect_pc = 32'h103; #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL redir_req got %h exp 0", imem_req); end
    @(negedge clk);
    redirect_valid = 1'b0; #1;
    checks++; if (inst_valid !== 1'b0 || misalign_err !== 1'b1) begin
      failures++; $display("FAIL redir_flush got v=%h mis=%h exp 0/1", inst_valid, misalign_err); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      failures++; $display("FAIL redir_addr got req=%h addr=%h exp 1/100", imem_req, imem_addr); end
    checks++; if (fetch_count !== 32'd8) begin failures++; $display("FAIL redir_count got %0d exp 8", fetch_count); end
    @(negedge clk); #1;
    checks++; if (misalign_err !== 1'b0 || inst_valid !== 1'b1 || current_procount !== 32'h100) begin
      failures++; $display("FAIL redir_after got mis=%h v=%h pc=%h exp 0/1/100", misalign_err, inst_valid, current_procount); end
  endtask

  task automatic test_wrap_halt();
    imem_ack = 1'b1; inst_ready = 1'b1;
    do_reset();
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC || misalign_err !== 1'b0) begin
      failures++; $display("FAIL wrap_top got req=%h addr=%h mis=%h", imem_req, imem_addr, misalign_err); end
    @(negedge clk);
    halt = 1'b1; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || current_procount !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_zero got req=%h addr=%h pc=%h exp 1/0/fffffffc", imem_req, imem_addr, current_procount); end
    @(negedge clk); #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h4 || current_procount !== 32'h0 || inst_valid !== 1'b1) begin
      failures++; $display("FAIL halt_in got req=%h addr=%h pc=%h v=%h exp 0/4/0/1", imem_req, imem_addr, current_procount, inst_valid); end
    @(negedge clk);
    halt = 1'b0; #1;
    checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
      failures++; $display("FAIL halt_drain got req=%h v=%h exp 0/0", imem_req, inst_valid); end
    @(negedge clk); #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      failures++; $display("FAIL halt_resume got req=%h addr=%h exp 1/4", imem_req, imem_addr); end
  endtask

  task automatic test_timeout();
    imem_ack = 1'b0; inst_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); #1;
      checks++; if (imem_req !== 1'b1 || bus_err !== 1'b0) begin
        failures++; $display("FAIL tmo_wait k=%0d got req=%h berr=%h exp 1/0", k, imem_req, bus_err); end
    end
    @(negedge clk); #1;
    checks++; if (imem_req !== 1'b0 || bus_err !== 1'b1) begin
      failures++; $display("FAIL tmo_err got req=%h berr=%h exp 0/1", imem_req, bus_err); end
    halt = 1'b1;
    @(negedge clk); #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL tmo_stay got %h exp 0", imem_req); end
    halt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || bus_err !== 1'b1) begin
      failures++; $display("FAIL tmo_exit got req=%h addr=%h berr=%h exp 1/40/1", imem_req, imem_addr, bus_err); end
  endtask

  // Continues from the ERROR-recovered state left by test_timeout.
  task automatic test_reset_mid();
    imem_ack = 1'b1; inst_ready = 1'b0;
    @(negedge clk); #1;
    checks++; if (inst_valid !== 1'b1 || bus_err !== 1'b1 || current_procount !== 32'h40) begin
      failures++; $display("FAIL mid_pre got v=%h berr=%h pc=%h exp 1/1/40", inst_valid, bus_err, current_procount); end
    rst_n = 1'b0; inst_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0 || bus_err !== 1'b0 || misalign_err !== 1'b0) begin
      failures++; $display("FAIL mid_flags got req=%h v=%h berr=%h mis=%h exp 0", imem_req, inst_valid, bus_err, misalign_err); end
    checks++; if (instruction !== 32'h0 || current_procount !== 32'h0 || fetch_count !== 32'h0 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL mid_regs got ins=%h pc=%h cnt=%h addr=%h exp 0", instruction, current_procount, fetch_count, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap_halt();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, fetch address loaded on reset.
REQ-002 Parameter: TIMEOUT, 16, consecutive unacknowledged request cycles before bus error (legal range 2..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 redirect_valid  input  1  branch/jump redirect strobe.
REQ-006 redirect_pc  input  32  redirect target address.
REQ-007 halt  input  1  level request to stop fetching.
REQ-008 imem_req  output  1  instruction memory request.
REQ-009 imem_addr  output  32  instruction memory address.
REQ-010 imem_ack  input  1  memory response valid; qualified by imem_req in the same cycle.
REQ-011 imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-012 inst_valid  output  1  output register holds an instruction.
REQ-013 inst_ready  input  1  downstream accepts the instruction.
REQ-014 instruction  output  32  fetched instruction.
REQ-015 current_procount  output  32  address of the instruction on instruction.
REQ-016 misalign_err  output  1  one-cycle pulse on misaligned redirect.
REQ-017 bus_err  output  1  sticky memory timeout flag.
REQ-018 fetch_count  output  32  count of instructions transferred downstream.

Function
REQ-019 States SHALL be IDLE, RUN, HALT, ERROR; internal pc register holds the next fetch address.
REQ-020 IDLE SHALL last exactly one cycle after reset release, then go to RUN.
REQ-021 imem_req SHALL be 1 only in RUN and when (!inst_valid || inst_ready) and !redirect_valid; imem_addr SHALL always equal pc.
REQ-022 Accept = imem_req && imem_ack: instruction<=imem_rdata, current_procount<=pc, inst_valid<=1, pc<=pc+4 next cycle; zero added latency, one instruction per cycle sustained.
REQ-023 pc increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 Transfer = inst_valid && inst_ready; without a same-cycle accept, inst_valid<=0; fetch_count<=fetch_count+1 (wrapping) on every transfer.
REQ-025 instruction and current_procount SHALL hold stable while inst_valid && !inst_ready.
REQ-026 redirect_valid SHALL win over every other event: pc<={redirect_pc[31:2],2'b00}, inst_valid<=0, same-cycle imem_ack discarded, timeout counter cleared; a same-cycle transfer still counts.
REQ-027 redirect_pc[1:0]!=0 with redirect_valid SHALL pulse misalign_err for the following cycle only.
REQ-028 halt in RUN SHALL move to HALT next cycle; a same-cycle accept still completes; in HALT imem_req=0, output register still drains normally.
REQ-029 HALT SHALL return to RUN the cycle after halt deasserts; redirect in HALT updates pc without leaving HALT.
REQ-030 Timeout counter SHALL increment each cycle imem_req=1 and imem_ack=0, clear on accept, redirect, or imem_req=0.
REQ-031 When the counter reaches TIMEOUT, state SHALL go to ERROR next cycle, bus_err<=1, imem_req=0.
REQ-032 ERROR SHALL ignore halt and exit to RUN only on redirect_valid (pc loaded per REQ-026); bus_err SHALL stay 1 until reset.

Reset
REQ-033 On rst_n=0 at a clock edge: state IDLE, pc=RESET_PC, imem_req=0, inst_valid=0, instruction=0, current_procount=RESET_PC, misalign_err=0, bus_err=0, fetch_count=0, timeout counter=0.
REQ-034 Reset SHALL take effect mid-transaction; any same-cycle imem_ack SHALL be discarded.

Verification
REQ-035 Reset, imem_ack tied 1, inst_ready tied 1 -> imem_addr 0,4,8,... one per cycle from the second cycle after release; fetch_count=10 after ten transfers.
REQ-036 inst_ready=0 for 3 cycles with valid instruction at 0x8 -> instruction and current_procount=0x8 stable, imem_req=0; resumes at 0xC when inst_ready=1.
REQ-037 redirect_valid with redirect_pc=0x103 during ack of 0x20 -> rdata dropped, inst_valid=0 next cycle, misalign_err pulse, next imem_addr=0x100.
REQ-038 imem_ack held 0 with TIMEOUT=16 -> after 16 request cycles ERROR, imem_req=0, bus_err=1; redirect to 0x40 -> RUN, imem_addr=0x40, bus_err still 1.
REQ-039 pc at 0xFFFF_FFFC, ack -> next imem_addr 0x0; halt asserted 2 cycles -> imem_req=0 then fetch resumes at held pc.
REQ-040 rst_n=0 while inst_valid=1 and bus_err=1 -> all outputs return to REQ-033 values next cycle.
